// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: widths, NOP encoding and
// the default reset fetch address.
package fetch_unit_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam int          ADDR_SIZE        = 32;
  localparam int          INSTR_SIZE       = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {pc, instr} pairs between fetch and decode.
// Flush empties it in one cycle; reset is asynchronous and active-high.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= PW'(0);
      wr_ptr <= PW'(0);
      count  <= CW'(0);
    end else if (flush) begin
      rd_ptr <= PW'(0);
      wr_ptr <= PW'(0);
      count  <= CW'(0);
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are meaningless while count says empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, queues fetched words for decode
// and restarts on redirect. Define FETCH_BYPASS_EN for zero-latency bypass.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int               DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pcplus4
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(32'd3);
  localparam logic [XLEN-1:0] NOP_WORD   = XLEN'(NOP_INSTR);

  logic [XLEN-1:0]   fpc;
  logic              q_full;
  logic              q_empty;
  logic              q_push;
  logic              q_pop;
  logic [2*XLEN-1:0] q_head;
  logic              bypass;
  logic              consume;
  logic              fpc_adv;

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .din   ({fpc, imem_instr}),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  assign imem_addr = fpc;

  // Handshake decisions and the decode-facing view of the queue head.
  always_comb begin
    bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass = q_empty && !redirect && !reset;
`else
    bypass = 1'b0;
`endif
    consume = bypass && instr_ready;
    q_push  = !redirect && !q_full && !consume;
    q_pop   = !q_empty && instr_ready && !redirect;
    fpc_adv = q_push || consume;

    if (bypass) begin
      instr_valid = 1'b1;
      instr       = imem_instr;
      instr_pc    = fpc;
    end else if (!q_empty) begin
      instr_valid = 1'b1;
      instr       = q_head[XLEN-1:0];
      instr_pc    = q_head[2*XLEN-1:XLEN];
    end else begin
      instr_valid = 1'b0;
      instr       = NOP_WORD;
      instr_pc    = XLEN'(32'd0);
    end
    instr_pcplus4 = instr_pc + PC_STEP;
  end

  // Fetch PC: redirect target (word aligned) beats sequential advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc <= RESET_PC;
    end else if (redirect) begin
      fpc <= redirect_pc & ALIGN_MASK;
    end else if (fpc_adv) begin
      fpc <= fpc + PC_STEP;
    end else begin
      fpc <= fpc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// reset/redirect sequences and a randomized run against a queue-based model.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pcplus4 (instr_pcplus4)
  );

  always #5 clk = ~clk;

  assign imem_instr = imem_addr ^ KEY;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares every output against an expected valid flag, head PC and fetch address.
  task automatic expect_out(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [31:0] eaddr);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, ev});
    chk({tag, ".addr"}, imem_addr, eaddr);
    if (ev) begin
      chk({tag, ".pc"}, instr_pc, epc);
      chk({tag, ".instr"}, instr, epc ^ KEY);
      chk({tag, ".pc4"}, instr_pcplus4, epc + 32'd4);
    end else begin
      chk({tag, ".pc"}, instr_pc, 32'd0);
      chk({tag, ".instr"}, instr, NOP);
      chk({tag, ".pc4"}, instr_pcplus4, 32'd4);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] rp, input logic rd);
    redirect    = r;
    redirect_pc = rp;
    instr_ready = rd;
    #1;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] mq [$];
  logic [31:0] mfpc;
  logic        mv;
  logic [31:0] mpc;
  logic        r_r;
  logic        r_d;
  logic [31:0] r_p;
  logic        cons;
  int          was;

  initial begin
    tbl[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0};
    tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h4};
    tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8};
    tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8};
    tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8};
    tbl[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h8};
    tbl[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h8};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'hC};
    tbl[8]  = '{1'b1, 32'h0000_0103, 1'b1, 1'b1, 32'h8,         32'h10};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h100};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       32'h104};
    tbl[11] = '{1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h104,       32'h108};
    tbl[12] = '{1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0,         32'h200};
    tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h300};
    tbl[14] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h300,       32'h304};
    tbl[15] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h304,       32'h308};
    tbl[16] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'hFFFF_FFFC};
    tbl[17] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0};
    tbl[18] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h4};

    // Reset state while reset is held.
    #1;
    expect_out("reset", 1'b0, 32'h0, 32'h0);

    // Directed table: stall/saturate, drain, redirects, PC wrap.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
      expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eaddr);
      @(negedge clk);
    end

    // Release with ready held high: one bubble, then 0, 4, 8, 12 back to back.
    do_reset();
    drive(1'b0, 32'h0, 1'b1);
    expect_out("stream0", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      expect_out($sformatf("stream%0d", k + 1), 1'b1, 32'(k * 4), 32'(k * 4 + 4));
      @(negedge clk);
    end

    // Asynchronous reset between edges with the queue full.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b0);
      @(negedge clk);
    end
    chk("prefull.valid", {31'd0, instr_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_rst", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized run against the queue model.
    mq.delete();
    mfpc = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      r_r = ($urandom_range(0, 9) == 0);
      r_p = $urandom;
      r_d = ($urandom_range(0, 3) != 0);
      drive(r_r, r_p, r_d);
      cons = 1'b0;
      if (mq.size() > 0) begin
        mv  = 1'b1;
        mpc = mq[0];
      end else begin
        mv  = 1'b0;
        mpc = 32'h0;
`ifdef FETCH_BYPASS_EN
        if (!r_r) begin
          mv   = 1'b1;
          mpc  = mfpc;
          cons = r_d;
        end
`endif
      end
      expect_out("rand", mv, mpc, mfpc);
      if (r_r) begin
        mq.delete();
        mfpc = {r_p[31:2], 2'b00};
      end else if (cons) begin
        mfpc = mfpc + 32'd4;
      end else begin
        was = mq.size();
        if (mv && r_d) begin
          void'(mq.pop_front());
        end
        if (was < 2) begin
          mq.push_back(mfpc);
          mfpc = mfpc + 32'd4;
        end
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
